// File: rtl/tdl_pkg.sv
// Shared constants and types for the tapped-delay-line serializer.
package tdl_pkg;

  localparam int unsigned TDL_WIDTH = 16;
  localparam int unsigned TDL_DEPTH = 2;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } tdl_state_e;

  // Index width needed to address DEPTH taps, never narrower than one bit.
  function automatic int unsigned tdl_idx_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/tap_serializer.sv
// Captures a parallel tap vector and streams its taps one per accepted cycle.
module tap_serializer
  import tdl_pkg::*;
#(
  parameter int unsigned  WIDTH   = TDL_WIDTH,
  parameter int unsigned  DEPTH   = TDL_DEPTH,
  parameter bit           REVERSE = 1'b0,
  localparam int unsigned IDX_W   = tdl_idx_w(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DEPTH-1:0][WIDTH-1:0] taps_in,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [IDX_W-1:0]            out_idx,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last
);

  localparam logic [IDX_W-1:0] FIRST_IDX = REVERSE ? IDX_W'(DEPTH - 1) : '0;
  localparam logic [IDX_W-1:0] LAST_IDX  = REVERSE ? '0 : IDX_W'(DEPTH - 1);

  tdl_state_e                  state_q;
  logic [DEPTH-1:0][WIDTH-1:0] snap_q;
  logic [IDX_W-1:0]            next_idx;
  logic                        in_xfer;
  logic                        out_xfer;

  // Handshakes; a new vector may enter while the last tap is leaving.
  assign out_xfer = out_valid && out_ready;
  assign in_ready = !rst && ((state_q == ST_IDLE) || (out_xfer && out_last));
  assign in_xfer  = in_valid && in_ready;

  // Step the tap index in the configured direction.
  always_comb begin
    next_idx = out_idx;
    if (REVERSE) begin
      next_idx = out_idx - IDX_W'(1);
    end else begin
      next_idx = out_idx + IDX_W'(1);
    end
  end

  // FSM, snapshot and registered output element.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      snap_q    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
    end else if (in_xfer) begin
      state_q   <= ST_STREAM;
      snap_q    <= taps_in;
      out_valid <= 1'b1;
      out_idx   <= FIRST_IDX;
      out_data  <= taps_in[FIRST_IDX];
      out_last  <= (FIRST_IDX == LAST_IDX);
    end else if (out_xfer) begin
      if (out_last) begin
        state_q   <= ST_IDLE;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else begin
        out_idx  <= next_idx;
        out_data <= snap_q[next_idx];
        out_last <= (next_idx == LAST_IDX);
      end
    end
  end

endmodule

// File: tb/tb_tap_serializer.sv
// Bench for tap_serializer: three configurations against a vector-level model.
module tb_tap_serializer;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0][15:0] taps;
  logic [2:0]       iv, irdy, ov, ordy, ol;
  logic [15:0]      od0, od1, od2;
  logic [1:0]       oi0, oi1;
  logic             oi2;

  int n_checks = 0;
  int n_errors = 0;

  // Model: per instance, whether a vector is pending, how many taps already
  // emitted, the captured vector, and whether outputs must read as reset.
  int               dep [3] = '{4, 4, 1};
  bit               rev [3] = '{1'b0, 1'b1, 1'b0};
  bit               m_act [3];
  int               m_k [3];
  logic [3:0][15:0] m_snap [3];
  bit               m_zero [3];

  always #5 clk = ~clk;

  tap_serializer #(.WIDTH(16), .DEPTH(4), .REVERSE(1'b0)) u0 (
    .clk(clk), .rst(rst), .taps_in(taps), .in_valid(iv[0]), .in_ready(irdy[0]),
    .out_data(od0), .out_idx(oi0), .out_valid(ov[0]), .out_ready(ordy[0]), .out_last(ol[0])
  );

  tap_serializer #(.WIDTH(16), .DEPTH(4), .REVERSE(1'b1)) u1 (
    .clk(clk), .rst(rst), .taps_in(taps), .in_valid(iv[1]), .in_ready(irdy[1]),
    .out_data(od1), .out_idx(oi1), .out_valid(ov[1]), .out_ready(ordy[1]), .out_last(ol[1])
  );

  tap_serializer #(.WIDTH(16), .DEPTH(1), .REVERSE(1'b0)) u2 (
    .clk(clk), .rst(rst), .taps_in(taps[0]), .in_valid(iv[2]), .in_ready(irdy[2]),
    .out_data(od2), .out_idx(oi2), .out_valid(ov[2]), .out_ready(ordy[2]), .out_last(ol[2])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] get_od(input int i);
    case (i)
      0:       return od0;
      1:       return od1;
      default: return od2;
    endcase
  endfunction

  function automatic logic [1:0] get_oi(input int i);
    case (i)
      0:       return oi0;
      1:       return oi1;
      default: return {1'b0, oi2};
    endcase
  endfunction

  // Tap index of the element the model says is on the output.
  function automatic int exp_idx(input int i);
    return rev[i] ? (dep[i] - 1 - m_k[i]) : m_k[i];
  endfunction

  function automatic bit exp_irdy(input int i);
    return !rst && (!m_act[i] || (ordy[i] && (m_k[i] == dep[i] - 1)));
  endfunction

  task automatic check_outputs();
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("u%0d.out_valid", i), 32'(ov[i]), 32'(m_act[i]));
      if (m_act[i]) begin
        check_eq($sformatf("u%0d.out_data", i), 32'(get_od(i)), 32'(m_snap[i][exp_idx(i)]));
        check_eq($sformatf("u%0d.out_idx", i), 32'(get_oi(i)), 32'(exp_idx(i)));
        check_eq($sformatf("u%0d.out_last", i), 32'(ol[i]), 32'(m_k[i] == dep[i] - 1));
      end else if (m_zero[i]) begin
        check_eq($sformatf("u%0d.out_data_rst", i), 32'(get_od(i)), 32'h0);
        check_eq($sformatf("u%0d.out_idx_rst", i), 32'(get_oi(i)), 32'h0);
        check_eq($sformatf("u%0d.out_last_rst", i), 32'(ol[i]), 32'h0);
      end
    end
  endtask

  // One clock: drive at negedge, check in_ready, advance model, check outputs.
  task automatic step(input bit r, input logic [2:0] v, input logic [2:0] rd,
                      input logic [3:0][15:0] t);
    bit ir_exp [3];
    rst  = r;
    iv   = v;
    ordy = rd;
    taps = t;
    #1;
    for (int i = 0; i < 3; i++) begin
      ir_exp[i] = exp_irdy(i);
      check_eq($sformatf("u%0d.in_ready", i), 32'(irdy[i]), 32'(ir_exp[i]));
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        m_act[i]  = 1'b0;
        m_k[i]    = 0;
        m_snap[i] = '0;
        m_zero[i] = 1'b1;
      end else begin
        if (m_act[i] && rd[i]) begin
          if (m_k[i] == dep[i] - 1) m_act[i] = 1'b0;
          else m_k[i]++;
        end
        if (v[i] && ir_exp[i]) begin
          m_act[i]  = 1'b1;
          m_k[i]    = 0;
          m_snap[i] = t;
          m_zero[i] = 1'b0;
        end
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  function automatic logic [3:0][15:0] rand_vec();
    logic [3:0][15:0] r;
    for (int j = 0; j < 4; j++) r[j] = 16'($urandom);
    return r;
  endfunction

  initial begin
    logic [3:0][15:0] vec1;
    logic [3:0][15:0] vec2;
    vec1 = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    vec2 = {16'h00D0, 16'h00C0, 16'h00B0, 16'h00A0};
    for (int i = 0; i < 3; i++) begin
      m_act[i] = 1'b0; m_k[i] = 0; m_snap[i] = '0; m_zero[i] = 1'b1;
    end
    rst = 1'b1; iv = '0; ordy = '0; taps = '0;
    @(negedge clk);

    // Reset, then a single vector streamed with the consumer always ready.
    step(1'b1, 3'b000, 3'b111, vec1);
    step(1'b1, 3'b111, 3'b111, vec1);
    step(1'b0, 3'b111, 3'b111, vec1);
    check_eq("fwd_first", 32'(od0), 32'h0001);
    check_eq("rev_first", 32'(od1), 32'h0004);
    check_eq("d1_first", 32'(od2), 32'h0001);
    for (int c = 0; c < 3; c++) step(1'b0, 3'b000, 3'b111, vec1);
    check_eq("fwd_last_data", 32'(od0), 32'h0004);
    check_eq("fwd_last_flag", 32'(ol[0]), 32'h1);
    check_eq("rev_last_idx", 32'(oi1), 32'h0);
    step(1'b0, 3'b000, 3'b111, vec1);
    check_eq("fwd_idle", 32'(ov[0]), 32'h0);

    // Backpressure on idx 1 while taps_in keeps changing.
    step(1'b0, 3'b111, 3'b111, vec1);
    step(1'b0, 3'b000, 3'b111, rand_vec());
    for (int c = 0; c < 3; c++) step(1'b0, 3'b111, 3'b000, rand_vec());
    check_eq("bp_data", 32'(od0), 32'h0002);
    check_eq("bp_idx", 32'(oi0), 32'h1);
    check_eq("bp_in_ready", 32'(irdy[0]), 32'h0);

    // Back-to-back reload as the last tap leaves.
    step(1'b0, 3'b000, 3'b111, vec1);
    step(1'b0, 3'b000, 3'b111, vec1);
    step(1'b0, 3'b111, 3'b111, vec2);
    check_eq("b2b_first", 32'(od0), 32'h00A0);
    for (int c = 0; c < 3; c++) step(1'b0, 3'b000, 3'b111, vec2);

    // Reset in mid-stream, then a fresh capture.
    step(1'b0, 3'b111, 3'b111, vec1);
    step(1'b0, 3'b000, 3'b111, vec1);
    step(1'b0, 3'b000, 3'b111, vec1);
    check_eq("pre_rst_idx", 32'(oi0), 32'h2);
    step(1'b1, 3'b111, 3'b111, vec2);
    check_eq("rst_valid", 32'(ov[0]), 32'h0);
    check_eq("rst_data", 32'(od0), 32'h0);
    step(1'b0, 3'b111, 3'b111, vec1);
    check_eq("post_rst_data", 32'(od0), 32'h0001);
    check_eq("post_rst_idx", 32'(oi0), 32'h0);

    // Randomised traffic, handshakes and occasional reset.
    for (int c = 0; c < 400; c++) begin
      logic [2:0] v;
      logic [2:0] rd;
      for (int i = 0; i < 3; i++) begin
        v[i]  = ($urandom_range(0, 1) == 1);
        rd[i] = ($urandom_range(0, 9) < 7);
      end
      step(($urandom_range(0, 39) == 0), v, rd, rand_vec());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tap_serializer.md
TAP_SERIALIZER -- requirements
Module: tap_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning bit width of one tap sample.
REQ-002 The block SHALL have parameter DEPTH, default 2, meaning number of taps per vector (DEPTH >= 1).
REQ-003 The block SHALL have parameter REVERSE, default 0, meaning 0 = emit tap 0 first, 1 = emit tap DEPTH-1 first.
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-006 The block SHALL have port taps_in, input, [DEPTH-1:0][WIDTH-1:0], meaning parallel tap vector, index 0 = newest sample.
REQ-007 The block SHALL have port in_valid, input, 1, meaning taps_in holds a vector to capture.
REQ-008 The block SHALL have port in_ready, output, 1, meaning the block accepts taps_in this cycle.
REQ-009 The block SHALL have port out_data, output, WIDTH, meaning the current serialized tap value.
REQ-010 The block SHALL have port out_idx, output, IDX_W = max(1, clog2(DEPTH)), meaning the tap index of out_data.
REQ-011 The block SHALL have port out_valid, output, 1, meaning out_data/out_idx/out_last are valid.
REQ-012 The block SHALL have port out_ready, input, 1, meaning the downstream consumer accepts the current element.
REQ-013 The block SHALL have port out_last, output, 1, meaning the current element is the final tap of the vector.

Function
REQ-014 The block SHALL be a two-state FSM: IDLE (no vector held) and STREAM (snapshot held, elements pending).
REQ-015 The block SHALL define input transfer as in_valid && in_ready and output transfer as out_valid && out_ready.
REQ-016 In IDLE, in_ready SHALL be 1; an input transfer SHALL copy taps_in into an internal snapshot register and enter STREAM next cycle.
REQ-017 In STREAM, in_ready SHALL be 1 only when the element being transferred out this cycle has out_last = 1 (combinational on out_ready).
REQ-018 out_valid SHALL be 1 exactly when in STREAM; first element appears the cycle after capture (latency 1).
REQ-019 Element order SHALL be idx 0,1,...,DEPTH-1 when REVERSE=0 and DEPTH-1,...,0 when REVERSE=1; out_data SHALL equal snapshot[out_idx].
REQ-020 out_last SHALL be 1 when out_idx is DEPTH-1 (REVERSE=0) or 0 (REVERSE=1).
REQ-021 While out_valid && !out_ready, out_data, out_idx and out_last SHALL hold unchanged; taps_in changes SHALL NOT affect them.
REQ-022 On output transfer of a non-last element, out_idx SHALL advance by one step the next cycle.
REQ-023 On output transfer of the last element with no simultaneous input transfer, the FSM SHALL return to IDLE and out_valid SHALL be 0 next cycle.
REQ-024 On output transfer of the last element with a simultaneous input transfer, the snapshot SHALL reload and the first element of the new vector SHALL appear next cycle with no bubble.
REQ-025 For DEPTH = 1, every element SHALL have out_last = 1 and out_idx = 0.
REQ-026 The block SHALL perform no arithmetic on samples; values pass bit-exact.

Reset
REQ-027 When rst = 1 at a clock edge, the FSM SHALL enter IDLE, and out_valid, out_last, out_idx, out_data and snapshot SHALL be 0.
REQ-028 Reset mid-STREAM SHALL discard the remaining elements; in_ready SHALL be 1 the first cycle after rst deasserts.
REQ-029 While rst = 1, in_ready SHALL be 0 and no capture SHALL occur.

Structure
REQ-030 A shared package tdl_pkg SHALL hold the default WIDTH/DEPTH constants and the FSM state enum type.
REQ-031 The block SHALL be a single module with no sub-modules; snapshot register, index counter and FSM are internal.

Verification
REQ-032 WIDTH=16, DEPTH=4, REVERSE=0: capture {0x0004,0x0003,0x0002,0x0001} (idx3..0) with out_ready=1 -> out_data 0x0001,0x0002,0x0003,0x0004 on 4 consecutive cycles starting 1 cycle after capture; out_last only on 0x0004.
REQ-033 Same vector with REVERSE=1 -> order 0x0004,0x0003,0x0002,0x0001; out_idx 3,2,1,0; out_last with idx 0.
REQ-034 Backpressure: out_ready low 3 cycles on idx 1 while taps_in changes -> out_data stays 0x0002, idx stays 1, in_ready stays 0.
REQ-035 Back-to-back: in_valid held with second vector {0x00D0,...,0x00A0} -> 0x00A0 appears the cycle after 0x0004 is accepted; 8 elements in 8 cycles.
REQ-036 Assert rst during idx 2 -> next cycle out_valid=0, all outputs 0; after deassert, new capture streams from idx 0.
REQ-037 DEPTH=1: capture 0x1234 -> one element, out_idx=0, out_last=1, then IDLE unless new input accepted same cycle.
